// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt sequencer: state encoding,
// default vector layout and the maximum number of sources.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } state_t;

  localparam logic [7:0] DEF_VECTOR_BASE   = 8'hF0;
  localparam int         DEF_VECTOR_STRIDE = 4;
  localparam int         NUM_SRC_MAX       = 8;

  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of i_eligible.
// Purely combinational and width-parameterised so other arbiters can reuse it.
module interrupt_controller_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_eligible,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_eligible;
    // Scan downwards so the lowest index is the last (winning) assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_eligible[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt sequencer: latches requests, masks them, and injects a
// vector call at an instruction boundary. Define INTERRUPT_LEVEL_TRIGGER_EN for level-sensitive requests.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int         NUM_SRC       = 4,
  parameter logic [7:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int         VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_w_enable,
  input  logic [NUM_SRC-1:0] mask_w_data,
  input  logic               cpu_ready,
  input  logic [7:0]         rom_pc,
  input  logic               clear_status,
  output logic               int_jump_enable,
  output logic [7:0]         int_jump_data,
  output logic               int_push_enable,
  output logic [7:0]         int_push_data,
  output logic               int_inhibit,
  output logic               int_active,
  output logic [NUM_SRC-1:0] int_status,
  output logic [NUM_SRC-1:0] pending
);

  localparam int IDX_W = idx_width(NUM_SRC);

  state_t             r_state;
  logic [IDX_W-1:0]   r_sel_idx;
  logic [7:0]         r_ret_pc;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_int_status;

  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_sel_onehot;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_dispatch;
  logic [7:0]         w_vector;

  assign w_sel_onehot = NUM_SRC'(1) << r_sel_idx;
  assign w_dispatch   = (r_state == DISPATCH);

`ifdef INTERRUPT_LEVEL_TRIGGER_EN
  assign w_pending = irq_src;
`else
  logic [NUM_SRC-1:0] r_prev_src;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_clear;

  assign w_clear = w_dispatch ? w_sel_onehot : '0;

  // A new rising edge on the same bit as the dispatch clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_src <= '0;
      r_pending  <= '0;
    end else begin
      r_prev_src <= irq_src;
      r_pending  <= (r_pending & ~w_clear) | (irq_src & ~r_prev_src);
    end
  end

  assign w_pending = r_pending;
`endif

  assign w_eligible = w_pending & r_mask;

  interrupt_controller_priority_encoder #(
    .WIDTH (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_eligible (w_eligible),
    .o_idx      (w_idx),
    .o_valid    (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (mask_w_enable) begin
      r_mask <= mask_w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel_idx    <= '0;
      r_ret_pc     <= '0;
      r_int_status <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid && cpu_ready) begin
            r_sel_idx <= w_idx;
            r_ret_pc  <= rom_pc;
            r_state   <= DISPATCH;
          end
        end
        DISPATCH: begin
          r_int_status <= w_sel_onehot;
          r_state      <= SERVICE;
        end
        SERVICE: begin
          if (clear_status) begin
            r_int_status <= '0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The fetched instruction is inhibited, so rom_pc itself is the return address.
  assign w_vector        = VECTOR_BASE + 8'(r_sel_idx) * 8'(VECTOR_STRIDE);
  assign int_jump_enable = w_dispatch;
  assign int_jump_data   = w_dispatch ? w_vector : 8'h00;
  assign int_push_enable = w_dispatch;
  assign int_push_data   = w_dispatch ? r_ret_pc : 8'h00;
  assign int_inhibit     = w_dispatch;
  assign int_active      = (r_state == SERVICE);
  assign int_status      = r_int_status;
  assign pending         = w_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (edge-triggered build): expected
// dispatches are queued as stimulus is driven and checked when the DUT jumps.
module tb_interrupt_controller;

  localparam int NUM_SRC = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_src;
  logic               mask_w_enable;
  logic [NUM_SRC-1:0] mask_w_data;
  logic               cpu_ready;
  logic [7:0]         rom_pc;
  logic               clear_status;
  logic               int_jump_enable;
  logic [7:0]         int_jump_data;
  logic               int_push_enable;
  logic [7:0]         int_push_data;
  logic               int_inhibit;
  logic               int_active;
  logic [NUM_SRC-1:0] int_status;
  logic [NUM_SRC-1:0] pending;

  typedef struct {
    logic [7:0] jump;
    logic [7:0] push;
  } exp_t;

  exp_t q_exp[$];
  int   tests    = 0;
  int   fails    = 0;
  int   n_pushed = 0;
  int   n_seen   = 0;

  interrupt_controller #(
    .NUM_SRC       (NUM_SRC),
    .VECTOR_BASE   (8'hF0),
    .VECTOR_STRIDE (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_src         (irq_src),
    .mask_w_enable   (mask_w_enable),
    .mask_w_data     (mask_w_data),
    .cpu_ready       (cpu_ready),
    .rom_pc          (rom_pc),
    .clear_status    (clear_status),
    .int_jump_enable (int_jump_enable),
    .int_jump_data   (int_jump_data),
    .int_push_enable (int_push_enable),
    .int_push_data   (int_push_data),
    .int_inhibit     (int_inhibit),
    .int_active      (int_active),
    .int_status      (int_status),
    .pending         (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_dispatch(input logic [7:0] jump, input logic [7:0] push);
    exp_t e;
    e.jump = jump;
    e.push = push;
    q_exp.push_back(e);
    n_pushed++;
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_w_enable = 1'b1;
    mask_w_data   = m;
    step();
    mask_w_enable = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  // Scoreboard side: every jump cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && int_jump_enable) begin
      exp_t e;
      n_seen++;
      if (q_exp.size() == 0) begin
        chk("unexpected_jump", {24'h0, int_jump_data}, 32'h0);
      end else begin
        e = q_exp.pop_front();
        $display("[TB] dispatch jump=%02h push=%02h (exp jump=%02h push=%02h)",
                 int_jump_data, int_push_data, e.jump, e.push);
        chk("jump_data", {24'h0, int_jump_data}, {24'h0, e.jump});
        chk("push_data", {24'h0, int_push_data}, {24'h0, e.push});
        chk("push_en",   {31'h0, int_push_enable}, 32'h1);
        chk("inhibit",   {31'h0, int_inhibit}, 32'h1);
        chk("active_in_dispatch", {31'h0, int_active}, 32'h0);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    irq_src       = '0;
    mask_w_enable = 1'b0;
    mask_w_data   = '0;
    cpu_ready     = 1'b0;
    rom_pc        = 8'h00;
    clear_status  = 1'b0;
    step();
    step();
    chk("rst_jump_en", {31'h0, int_jump_enable}, 32'h0);
    chk("rst_push_en", {31'h0, int_push_enable}, 32'h0);
    chk("rst_active",  {31'h0, int_active}, 32'h0);
    chk("rst_status",  {28'h0, int_status}, 32'h0);
    chk("rst_pending", {28'h0, pending}, 32'h0);
    rst_n = 1'b1;
    step();

    // Single source 2 request.
    write_mask(4'b1111);
    cpu_ready = 1'b1;
    rom_pc    = 8'h23;
    irq_src   = 4'b0100;
    step();
    chk("t1_pending", {28'h0, pending}, 32'h4);
    chk("t1_no_jump_yet", {31'h0, int_jump_enable}, 32'h0);
    irq_src = 4'b0000;
    expect_dispatch(8'hF8, 8'h23);
    step();
    chk("t1_jump_now", {31'h0, int_jump_enable}, 32'h1);
    step();
    chk("t1_status", {28'h0, int_status}, 32'h4);
    chk("t1_active", {31'h0, int_active}, 32'h1);
    chk("t1_pending_clr", {28'h0, pending}, 32'h0);

    // New request during service latches but does not nest.
    irq_src = 4'b0001;
    step();
    irq_src = 4'b0000;
    step();
    step();
    chk("t4_pending", {28'h0, pending}, 32'h1);
    chk("t4_still_active", {31'h0, int_active}, 32'h1);
    pulse_clear();
    chk("t4_idle_active", {31'h0, int_active}, 32'h0);
    chk("t4_idle_status", {28'h0, int_status}, 32'h0);
    rom_pc = 8'h40;
    expect_dispatch(8'hF0, 8'h40);
    step();
    step();
    chk("t4_status", {28'h0, int_status}, 32'h1);
    pulse_clear();

    // Simultaneous sources 1 and 3: priority order.
    irq_src = 4'b1010;
    step();
    irq_src = 4'b0000;
    rom_pc  = 8'h50;
    expect_dispatch(8'hF4, 8'h50);
    step();
    step();
    chk("t2_status", {28'h0, int_status}, 32'h2);
    chk("t2_pending", {28'h0, pending}, 32'h8);
    step();
    step();
    step();
    pulse_clear();
    chk("t2_pending_idle", {28'h0, pending}, 32'h8);
    rom_pc = 8'h60;
    expect_dispatch(8'hFC, 8'h60);
    step();
    step();
    chk("t2_status3", {28'h0, int_status}, 32'h8);
    pulse_clear();

    // Masked source stays pending until enabled.
    write_mask(4'b0000);
    irq_src = 4'b0001;
    step();
    irq_src = 4'b0000;
    step();
    step();
    chk("t3_pending", {28'h0, pending}, 32'h1);
    chk("t3_no_jump", {31'h0, int_jump_enable}, 32'h0);
    write_mask(4'b0001);
    rom_pc = 8'h70;
    expect_dispatch(8'hF0, 8'h70);
    step();
    step();
    chk("t3_status", {28'h0, int_status}, 32'h1);
    pulse_clear();

    // No instruction boundary: hold off.
    write_mask(4'b1111);
    cpu_ready = 1'b0;
    irq_src   = 4'b0100;
    step();
    irq_src = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      rom_pc = 8'h90 + 8'(i);
      step();
      chk("t5_push_en", {31'h0, int_push_enable}, 32'h0);
      chk("t5_inhibit", {31'h0, int_inhibit}, 32'h0);
    end
    rom_pc    = 8'h9A;
    cpu_ready = 1'b1;
    expect_dispatch(8'hF8, 8'h9A);
    step();
    step();
    chk("t5_active", {31'h0, int_active}, 32'h1);

    // Asynchronous reset during service.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_active", {31'h0, int_active}, 32'h0);
    chk("t6_status", {28'h0, int_status}, 32'h0);
    chk("t6_pending", {28'h0, pending}, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    irq_src = 4'b0001;
    step();
    irq_src = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_push", {31'h0, int_push_enable}, 32'h0);
    end
    chk("t6_pending_masked", {28'h0, pending}, 32'h1);

    chk("queue_drained", q_exp.size(), 32'h0);
    chk("dispatch_count", n_seen, n_pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
